// File: rtl/pwm_pkg.sv
// Shared widths, scheduler state encoding and the duty-bus slice helper for the
// PWM frame scheduler and its watchdog.
package pwm_pkg;

  localparam int CHANNELS   = 8;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PENDING
  } schedState_t;

  // Channel n occupies bits [n*DATA_WIDTH +: DATA_WIDTH] of the packed duty bus.
  function automatic logic [DATA_WIDTH-1:0] dutySlice(
    input logic [CHANNELS*DATA_WIDTH-1:0] bus,
    input int unsigned                    channel
  );
    return bus[channel*DATA_WIDTH +: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/pwm_watchdog.sv
// Saturating commit watchdog: expired rises WATCHDOG_CYCLES edges after the last
// clear and stays high until the next clear; it starts expired out of reset.
module pwm_watchdog
#(
  parameter int WATCHDOG_CYCLES = 12000000
)
(
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic expired
);

  localparam int CountWidth = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [CountWidth-1:0] CountMax = CountWidth'(WATCHDOG_CYCLES - 1);

  logic [CountWidth-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count   <= CountMax;
      expired <= 1'b1;
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      if (count != CountMax) begin
        count <= count + 1'b1;
      end
      if (count == CountMax) begin
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_frame_scheduler.sv
// Collects an in-sequence frame of duty words into shadow registers and commits
// it to the active duties only on a PWM period boundary; a watchdog blanks stale duties.
module pwm_frame_scheduler
  import pwm_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = 12000000
)
(
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [ADDR_WIDTH-1:0]          wr_address,
  input  logic                           wr_strobe,
  input  logic                           period_start,
  output logic [CHANNELS*DATA_WIDTH-1:0] duty,
  output logic                           commit,
  output logic                           frame_error,
  output logic [7:0]                     error_count,
  output logic                           blanked
);

  localparam logic [ADDR_WIDTH-1:0] LastAddress = ADDR_WIDTH'(CHANNELS - 1);
  localparam logic [ADDR_WIDTH-1:0] SecondAddress = ADDR_WIDTH'(1);

  schedState_t           state, stateNext;
  logic [ADDR_WIDTH-1:0] expected, expectedNext;
  logic                  shadowWrite;
  logic                  commitNext;
  logic                  errorNext;

  logic [DATA_WIDTH-1:0] shadow [CHANNELS];
  logic [DATA_WIDTH-1:0] active [CHANNELS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      expected <= '0;
    end else begin
      state    <= stateNext;
      expected <= expectedNext;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    stateNext    = state;
    expectedNext = expected;
    shadowWrite  = 1'b0;
    commitNext   = 1'b0;
    errorNext    = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_strobe) begin
          if (wr_address == '0) begin
            shadowWrite  = 1'b1;
            expectedNext = SecondAddress;
            stateNext    = FILL;
          end else begin
            errorNext = 1'b1;
          end
        end
      end
      FILL: begin
        if (wr_strobe) begin
          if (wr_address == expected) begin
            shadowWrite  = 1'b1;
            expectedNext = expected + 1'b1;
            if (wr_address == LastAddress) begin
              stateNext = PENDING;
            end
          end else if (wr_address == '0) begin
            shadowWrite  = 1'b1;
            expectedNext = SecondAddress;
            errorNext    = 1'b1;
          end else begin
            errorNext    = 1'b1;
            expectedNext = '0;
            stateNext    = IDLE;
          end
        end
      end
      PENDING: begin
        // A write alongside period_start is handled as if the commit already
        // moved us to IDLE; a write alone is an overrun and drops the frame.
        if (period_start) begin
          commitNext   = 1'b1;
          expectedNext = '0;
          stateNext    = IDLE;
        end
        if (wr_strobe) begin
          errorNext = !period_start || (wr_address != '0);
          if (wr_address == '0) begin
            shadowWrite  = 1'b1;
            expectedNext = SecondAddress;
            stateNext    = FILL;
          end else begin
            expectedNext = '0;
            stateNext    = IDLE;
          end
        end
      end
      default: begin
        expectedNext = '0;
        stateNext    = IDLE;
      end
    endcase
  end

  // NOTE: shadow and active are small flop banks, not RAM, so they take the
  // async reset like any other register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit      <= 1'b0;
      frame_error <= 1'b0;
      error_count <= '0;
    end else begin
      commit      <= commitNext;
      frame_error <= errorNext;
      if (errorNext && (error_count != 8'hFF)) begin
        error_count <= error_count + 8'd1;
      end
      if (shadowWrite) begin
        shadow[wr_address] <= wr_data;
      end
      // Commit reads the shadow before this edge's write lands.
      if (commitNext) begin
        for (int i = 0; i < CHANNELS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  // Cleared by the same edge that raises commit, so blanked drops with commit.
  pwm_watchdog #(
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (commitNext),
    .expired (blanked)
  );

  for (genvar n = 0; n < CHANNELS; n++) begin : gDuty
    assign duty[n*DATA_WIDTH +: DATA_WIDTH] = blanked ? '0 : active[n];
  end

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Bench for pwm_frame_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a frame-level reference model.
module tb_pwm_frame_scheduler;
  import pwm_pkg::*;

  localparam int WD = 100;
  localparam int DW = CHANNELS * DATA_WIDTH;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b1;
  logic [DATA_WIDTH-1:0] wr_data = '0;
  logic [ADDR_WIDTH-1:0] wr_address = '0;
  logic                  wr_strobe = 1'b0;
  logic                  period_start = 1'b0;
  logic [DW-1:0]         duty;
  logic                  commit;
  logic                  frame_error;
  logic [7:0]            error_count;
  logic                  blanked;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  always #5 clock = ~clock;

  pwm_frame_scheduler #(
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr_data      (wr_data),
    .wr_address   (wr_address),
    .wr_strobe    (wr_strobe),
    .period_start (period_start),
    .duty         (duty),
    .commit       (commit),
    .frame_error  (frame_error),
    .error_count  (error_count),
    .blanked      (blanked)
  );

  task automatic check(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, actual, required);
    end
  endtask

  // Reference model: a frame is the count of consecutive in-order words seen so far;
  // a full count means a frame waits for the period boundary.
  logic [DATA_WIDTH-1:0] mShadow [CHANNELS];
  logic [DATA_WIDTH-1:0] mActive [CHANNELS];
  int     mCollected;
  int     mErrCnt;
  bit     mCommit, mErr, mBlanked;
  longint mCycle, mLastCommit;
  bit     wasPending;
  int     addr;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mShadow[i] = '0;
        mActive[i] = '0;
      end
      mCollected  = 0;
      mErrCnt     = 0;
      mCommit     = 1'b0;
      mErr        = 1'b0;
      mCycle      = 0;
      mLastCommit = -1;
      mBlanked    = 1'b1;
    end else begin
      mCycle++;
      mCommit    = 1'b0;
      mErr       = 1'b0;
      wasPending = (mCollected == CHANNELS);
      addr       = int'(wr_address);
      if (wasPending && period_start) begin
        mActive     = mShadow;
        mCommit     = 1'b1;
        mLastCommit = mCycle;
        mCollected  = 0;
      end
      if (wr_strobe) begin
        if (wasPending && !period_start) begin
          mErr       = 1'b1;
          mCollected = 0;
        end
        if (addr == mCollected) begin
          mShadow[addr] = wr_data;
          mCollected++;
        end else if (addr == 0) begin
          mShadow[0] = wr_data;
          mCollected = 1;
          mErr       = 1'b1;
        end else begin
          mCollected = 0;
          mErr       = 1'b1;
        end
      end
      if (mErr && mErrCnt < 255) mErrCnt++;
      mBlanked = (mLastCommit < 0) || (mCycle - mLastCommit >= WD);
    end
  end

  logic [DW-1:0] expDuty;

  always @(negedge clock) begin
    if (checkEn) begin
      for (int n = 0; n < CHANNELS; n++) begin
        expDuty[n*DATA_WIDTH +: DATA_WIDTH] = mBlanked ? '0 : mActive[n];
      end
      check("duty", duty, expDuty);
      check("commit", DW'(commit), DW'(mCommit));
      check("frame_error", DW'(frame_error), DW'(mErr));
      check("error_count", DW'(error_count), DW'(mErrCnt));
      check("blanked", DW'(blanked), DW'(mBlanked));
    end
  end

  task automatic step(input bit s, input int a, input logic [DATA_WIDTH-1:0] d, input bit p);
    @(negedge clock);
    wr_strobe    = s;
    wr_address   = ADDR_WIDTH'(a);
    wr_data      = d;
    period_start = p;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, '0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clock);
    wr_strobe    = 1'b0;
    period_start = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic writeFrame(input logic [DATA_WIDTH-1:0] base, input logic [DATA_WIDTH-1:0] inc);
    for (int n = 0; n < CHANNELS; n++) begin
      step(1'b1, n, base + inc * DATA_WIDTH'(n), 1'b0);
    end
  endtask

  function automatic logic [DW-1:0] ch(input int n);
    return DW'(dutySlice(duty, n));
  endfunction

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_blanked", DW'(blanked), DW'(1));
    check("reset_duty", duty, '0);
    check("reset_error_count", DW'(error_count), '0);
    check("reset_commit", DW'(commit), '0);
    checkEn = 1'b1;
    reset_n = 1'b1;

    // Normal frame, period boundary 5 cycles later.
    for (int n = 0; n < CHANNELS; n++) step(1'b1, n, DATA_WIDTH'(16'h1000 * (n + 1)), 1'b0);
    idle(5);
    step(1'b0, 0, '0, 1'b1);
    check("normal_commit_early", DW'(commit), '0);
    idle(1);
    check("normal_commit", DW'(commit), DW'(1));
    check("normal_ch3", ch(3), DW'(16'h4000));
    check("normal_blanked", DW'(blanked), '0);
    check("normal_error_count", DW'(error_count), '0);
    idle(1);
    check("normal_commit_single", DW'(commit), '0);

    // Full frame held for 50 cycles without a period boundary.
    doReset();
    writeFrame(16'h2000, 16'h0100);
    idle(50);
    check("hold_duty", duty, '0);
    check("hold_blanked", DW'(blanked), DW'(1));
    step(1'b0, 0, '0, 1'b1);
    idle(1);
    check("hold_commit", DW'(commit), DW'(1));
    check("hold_ch7", ch(7), DW'(16'h2700));

    // Out-of-sequence address.
    doReset();
    step(1'b1, 0, 16'h0001, 1'b0);
    step(1'b1, 1, 16'h0002, 1'b0);
    step(1'b1, 2, 16'h0003, 1'b0);
    step(1'b1, 5, 16'h0004, 1'b0);
    idle(1);
    check("oos_frame_error", DW'(frame_error), DW'(1));
    check("oos_error_count", DW'(error_count), DW'(1));
    step(1'b0, 0, '0, 1'b1);
    idle(1);
    check("oos_no_commit", DW'(commit), '0);

    // Restart followed by overrun.
    doReset();
    step(1'b1, 0, 16'h00AA, 1'b0);
    step(1'b1, 1, 16'h00BB, 1'b0);
    step(1'b1, 0, 16'h0A00, 1'b0);
    step(1'b1, 1, 16'h0A01, 1'b0);
    check("restart_frame_error", DW'(frame_error), DW'(1));
    check("restart_error_count", DW'(error_count), DW'(1));
    for (int n = 2; n < CHANNELS; n++) step(1'b1, n, DATA_WIDTH'(16'h0A00 + n), 1'b0);
    idle(1);
    step(1'b1, 0, 16'h5555, 1'b0);
    idle(1);
    check("overrun_frame_error", DW'(frame_error), DW'(1));
    check("overrun_error_count", DW'(error_count), DW'(2));
    step(1'b0, 0, '0, 1'b1);
    idle(1);
    check("overrun_no_commit", DW'(commit), '0);

    // Write and period boundary in the same cycle.
    doReset();
    writeFrame(16'h1111, 16'h1111);
    step(1'b0, 0, '0, 1'b1);
    idle(1);
    writeFrame(16'h0A00, 16'h0001);
    step(1'b1, 0, 16'hBEEF, 1'b1);
    idle(1);
    check("simul_commit", DW'(commit), DW'(1));
    check("simul_ch0_old", ch(0), DW'(16'h0A00));
    for (int n = 1; n < CHANNELS; n++) step(1'b1, n, DATA_WIDTH'(16'hC000 + n), 1'b0);
    step(1'b0, 0, '0, 1'b1);
    idle(1);
    check("simul_next_commit", DW'(commit), DW'(1));
    check("simul_ch0_beef", ch(0), DW'(16'hBEEF));
    check("simul_ch1", ch(1), DW'(16'hC001));
    check("simul_error_count", DW'(error_count), '0);

    // Watchdog expiry WD cycles after the commit, then recovery and async reset.
    idle(WD - 1);
    check("wd_not_yet", DW'(blanked), '0);
    idle(1);
    check("wd_blanked", DW'(blanked), DW'(1));
    check("wd_duty_zero", duty, '0);
    writeFrame(16'h3000, 16'h0010);
    step(1'b0, 0, '0, 1'b1);
    idle(1);
    check("wd_recover_blanked", DW'(blanked), '0);
    check("wd_recover_ch2", ch(2), DW'(16'h3020));
    step(1'b1, 0, 16'h7777, 1'b0);
    step(1'b1, 1, 16'h8888, 1'b0);
    check("prereset_blanked", DW'(blanked), '0);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_blanked", DW'(blanked), DW'(1));
    check("async_reset_duty", duty, '0);
    @(negedge clock);
    wr_strobe = 1'b0;
    reset_n   = 1'b1;

    // Error counter saturation.
    doReset();
    repeat (300) step(1'b1, 7, 16'h0000, 1'b0);
    idle(1);
    check("err_saturated", DW'(error_count), DW'(255));

    // Randomized traffic, biased toward in-sequence addresses.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      int a;
      a = ($urandom_range(7) == 0) ? int'($urandom_range(7)) : (mCollected % CHANNELS);
      step(1'($urandom_range(1)), a, 16'($urandom), ($urandom_range(5) == 0));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_frame_scheduler.md
Name: pwm_frame_scheduler

Overview:
- Sits between the SPI frame receiver and the PWM channel bank.
- Collects one 16-bit duty word per channel address (0..7) into shadow registers and checks that the addresses arrive in sequence.
- Commits a complete frame to the active duty registers only on a PWM period boundary, so outputs never glitch mid-period.
- A watchdog blanks all duties to zero if no frame commits within a timeout.

Parameters:
- CHANNELS, 8, number of PWM channels; must equal 2^ADDR_WIDTH.
- DATA_WIDTH, 16, duty word width.
- ADDR_WIDTH, 3, frame address width.
- WATCHDOG_CYCLES, 12000000, clock cycles without a commit before the outputs blank (1 s at 12 MHz).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_data  in  DATA_WIDTH  duty word from the receiver.
- wr_address  in  ADDR_WIDTH  channel index for wr_data.
- wr_strobe  in  1  one-cycle pulse; wr_data and wr_address are valid.
- period_start  in  1  one-cycle pulse at PWM counter wrap.
- duty  out  CHANNELS*DATA_WIDTH  active duties, channel n at bits [n*DATA_WIDTH +: DATA_WIDTH].
- commit  out  1  one-cycle pulse when the active registers update.
- frame_error  out  1  one-cycle pulse on an out-of-sequence address or a frame overrun.
- error_count  out  8  saturating error counter.
- blanked  out  1  high while duty is forced to zero.

Behaviour:
- Reset (async on reset_n low):
  - State IDLE; expected address 0.
  - Shadow and active registers 0; error_count 0.
  - blanked=1, commit=0, frame_error=0.
- States: IDLE, FILL, PENDING.
- IDLE:
  - wr_strobe with address 0: write shadow[0], expected=1, go to FILL.
  - wr_strobe with any other address: frame_error pulse, stay in IDLE.
- FILL:
  - wr_strobe with address == expected: write the shadow slot, expected+1.
  - When address CHANNELS-1 is written, go to PENDING.
  - wr_strobe with address 0: restart. Write shadow[0], expected=1, frame_error pulse.
  - Any other address: frame_error pulse, go to IDLE; the shadow contents are then don't-care.
- PENDING:
  - period_start: on the next edge, active <= shadow and commit=1 for that one cycle. Go to IDLE.
  - Latency is 1 cycle: period_start high in cycle N, new duty visible in cycle N+1.
  - wr_strobe without period_start: overrun. Discard the pending frame and pulse frame_error. If the address is 0, start a new FILL; otherwise go to IDLE.
  - wr_strobe and period_start in the same cycle: commit the existing shadow first, then process the write as it would be processed in IDLE. The commit captures the pre-write shadow value.
- period_start outside PENDING: ignored.
- error_count:
  - Increments on every frame_error pulse and saturates at 255.
  - At most one increment per cycle.
- Watchdog:
  - The counter clears on commit.
  - Otherwise it increments, saturating at WATCHDOG_CYCLES-1.
  - blanked=1 when saturated or since reset; blanked=0 from the commit cycle onward.
- duty output is 0 when blanked=1, otherwise the active registers. The active registers retain their values while blanked.
- All outputs are registered except duty, which is the active registers gated by blanked. There are no combinational paths from inputs to outputs.
- Reset mid-frame: the shadow is lost; outputs are blanked immediately (asynchronously).

Decomposition:
- Shared package pwm_pkg holds:
  - CHANNELS, DATA_WIDTH, ADDR_WIDTH.
  - The state enum {IDLE, FILL, PENDING}.
  - The duty slice helper.
- Sub-module pwm_watchdog: saturating counter with a clear input and an expired output, parameterised on WATCHDOG_CYCLES.

Test Plan:
- Normal frame:
  - Stimulus: writes of 0x1000*(n+1) to addresses 0..7, then period_start 5 cycles later.
  - Required: commit pulses exactly one cycle after period_start. Channel 3 duty = 0x4000, blanked=0, error_count=0.
- No commit before period boundary:
  - Stimulus: a full frame with no period_start for 50 cycles.
  - Required: duty unchanged (all 0, blanked) and no commit pulse. A later period_start commits the frame.
- Out-of-sequence address:
  - Stimulus: addresses 0,1,2,5.
  - Required: frame_error on the address-5 write and error_count=1. A following period_start produces no commit.
- Restart and overrun:
  - Stimulus: addresses 0,1,0..7. Then, with the frame in PENDING, a write to address 0 arrives without period_start.
  - Required: the address-0 restart pulses frame_error and error_count reaches 1. The overrun discards the pending frame and error_count reaches 2.
- Simultaneous write and period_start:
  - Stimulus: in PENDING, wr_strobe (address 0, 0xBEEF) and period_start in the same cycle.
  - Required: commit of the old shadow, channel 0 duty ≠ 0xBEEF. State becomes FILL with shadow[0]=0xBEEF.
- Watchdog and reset:
  - Stimulus: WATCHDOG_CYCLES=100, one commit, then idle.
  - Required: blanked rises 100 cycles after the commit and duty = 0. A new commit clears blanked and restores the new duties. Asserting reset_n low mid-FILL forces blanked=1 with no clock edge.
